// File: rtl/systolic_master_send_tx_if.sv
// systolic_master_send_tx_if
//   Bundles the two streams handled by the MasterSend transmitter:
//     upstream spike source : src_valid / src_data / src_ready
//     MasterSend link       : send_valid / send_data / send_done
//     credit return         : pkg_consumed (slave read one packet from its FIFO)
//   modport master : the transmitter side
//   modport slave  : the environment (source + SystolicController slave)
interface systolic_master_send_tx_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  src_valid;
   logic [DATA_WIDTH-1:0] src_data;
   logic                  src_ready;
   logic                  send_valid;
   logic [DATA_WIDTH-1:0] send_data;
   logic                  send_done;
   logic                  pkg_consumed;

   modport master (
      input  src_valid, src_data, pkg_consumed,
      output src_ready, send_valid, send_data, send_done
   );

   modport slave (
      output src_valid, src_data, pkg_consumed,
      input  src_ready, send_valid, send_data, send_done
   );
endinterface

// File: rtl/systolic_master_send_tx.sv
// systolic_master_send_tx
//   Frames upstream spike words into PKG_WORDS-word packets on the MasterSend
//   link and sends one line (PKGS_PER_LINE packets) per i_start. A packet may
//   only begin while a credit is available, so the slave FIFO and its 4-bit
//   packet pointers can never be overrun.
// Ports
//   s_clk, s_rst   clock, asynchronous active-high reset
//   i_start        pulse, starts a line (accepted in idle only)
//   bus (master)   source stream in, link out, pkg_consumed credit return
//   o_busy         not idle
//   o_line_done    one-cycle pulse after the last packet of the line
//   o_credit_err   sticky: credit returned while credits already full
//   o_stall_cycles (only with MASTER_SEND_TX_STATS_EN) cycles waiting for
//                  credit or for source data, saturating
module systolic_master_send_tx #(
   parameter int DATA_WIDTH    = 64,
   parameter int PKG_WORDS     = 16,
   parameter int PKGS_PER_LINE = 24,
   parameter int CREDIT_MAX    = 8
) (
   input  logic                          s_clk,
   input  logic                          s_rst,
   input  logic                          i_start,
   systolic_master_send_tx_if.master     bus,
   output logic                          o_busy,
   output logic                          o_line_done,
   output logic                          o_credit_err
`ifdef MASTER_SEND_TX_STATS_EN
   ,
   output logic [15:0]                   o_stall_cycles
`endif
);

   localparam int WC_W = (PKG_WORDS > 1) ? $clog2(PKG_WORDS) : 1;
   localparam int PC_W = (PKGS_PER_LINE > 1) ? $clog2(PKGS_PER_LINE) : 1;
   localparam int CR_W = $clog2(CREDIT_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_CRED, S_SEND, S_DONE} state_t;

   state_t          state;
   logic [WC_W-1:0] word_cnt;
   logic [PC_W-1:0] pkg_cnt;
   logic [CR_W-1:0] credit_cnt;
   logic            xfer;
   logic            first_word;
   logic            last_word;
   logic            take;
   logic            give;

   // ready depends on state only, never on src_valid
   assign bus.src_ready = (state == S_SEND);
   assign xfer          = bus.src_ready & bus.src_valid;
   assign first_word    = (word_cnt == '0);
   assign last_word     = (word_cnt == WC_W'(PKG_WORDS - 1));
   assign take          = xfer & first_word;
   assign give          = bus.pkg_consumed;

   // control FSM; busy/line_done are registered alongside the state
   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         state       <= S_IDLE;
         pkg_cnt     <= '0;
         word_cnt    <= '0;
         o_busy      <= 1'b0;
         o_line_done <= 1'b0;
      end else begin
         o_line_done <= 1'b0;
         case (state)
            S_IDLE: if (i_start) begin
               state   <= S_WAIT_CRED;
               pkg_cnt <= '0;
               o_busy  <= 1'b1;
            end
            S_WAIT_CRED: if (credit_cnt != '0) state <= S_SEND;
            S_SEND: if (xfer && last_word) begin
               if (pkg_cnt == PC_W'(PKGS_PER_LINE - 1)) begin
                  state       <= S_DONE;
                  o_line_done <= 1'b1;
               end else begin
                  pkg_cnt <= pkg_cnt + PC_W'(1);
                  state   <= S_WAIT_CRED;
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               o_busy <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
         if (xfer) word_cnt <= last_word ? '0 : word_cnt + WC_W'(1);
      end
   end

   // link stage: one cycle behind the source transfer, data holds when idle
   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         bus.send_valid <= 1'b0;
         bus.send_done  <= 1'b0;
         bus.send_data  <= '0;
      end else begin
         bus.send_valid <= xfer;
         bus.send_done  <= xfer & last_word;
         if (xfer) bus.send_data <= bus.src_data;
      end
   end

   // credits: a packet claims one on its first word. A return in the same
   // cycle cancels out, so it is not counted as an overflow.
   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         credit_cnt   <= CR_W'(CREDIT_MAX);
         o_credit_err <= 1'b0;
      end else begin
         case ({take, give})
            2'b10: credit_cnt <= credit_cnt - CR_W'(1);
            2'b01: begin
               if (credit_cnt == CR_W'(CREDIT_MAX)) o_credit_err <= 1'b1;
               else                                 credit_cnt   <= credit_cnt + CR_W'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef MASTER_SEND_TX_STATS_EN
   logic stall;
   assign stall = (state == S_WAIT_CRED) | ((state == S_SEND) & ~bus.src_valid);

   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst)                                o_stall_cycles <= '0;
      else if ((state == S_IDLE) && i_start)    o_stall_cycles <= '0;
      else if (stall && (o_stall_cycles != 16'hFFFF))
         o_stall_cycles <= o_stall_cycles + 16'd1;
   end
`endif

endmodule

// File: tb/tb_systolic_master_send_tx.sv
module tb_systolic_master_send_tx;
   localparam int DW         = 64;
   localparam int PW         = 16;
   localparam int PL         = 24;
   localparam int CMAX       = 8;
   localparam int LINE_WORDS = PW * PL;

   logic s_clk = 1'b0;
   logic s_rst = 1'b1;
   logic i_start = 1'b0;
   logic busy, line_done, credit_err;
`ifdef MASTER_SEND_TX_STATS_EN
   logic [15:0] stall_cycles;
   int          stall_m = 0;
`endif

   systolic_master_send_tx_if #(.DATA_WIDTH(DW)) bus ();

   systolic_master_send_tx #(
      .DATA_WIDTH(DW), .PKG_WORDS(PW), .PKGS_PER_LINE(PL), .CREDIT_MAX(CMAX)
   ) dut (
      .s_clk        (s_clk),
      .s_rst        (s_rst),
      .i_start      (i_start),
      .bus          (bus),
      .o_busy       (busy),
      .o_line_done  (line_done),
      .o_credit_err (credit_err)
`ifdef MASTER_SEND_TX_STATS_EN
      ,
      .o_stall_cycles (stall_cycles)
`endif
   );

   always #5 s_clk = ~s_clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // bench-side model: expected link words in source order, packet
   // positions on both sides, and packets started vs. credits returned
   logic [DW-1:0] exp_q[$];
   int            due_q[$];
   logic [DW-1:0] next_word;
   logic [DW-1:0] exp_w;
   int  cyc = 0;
   int  src_ptr = 0, link_ptr = 0;
   int  link_line = 0, done_line = 0, ld_cnt = 0;
   int  done_tot = 0, consumed = 0, started = 0;
   int  valid_pct = 100;
   bit  src_on = 0, auto_cons = 0, arm_co = 0, cons;

   always @(negedge s_clk) begin
      cyc++;
      if (bus.send_done && !bus.send_valid) chk("done_without_valid", 1, 0);
      if (bus.send_valid) begin
         if (exp_q.size() == 0) chk("unexpected_link_word", 1, 0);
         else begin
            exp_w = exp_q.pop_front();
            chk("link_data", bus.send_data, exp_w);
         end
         chk("link_done", bus.send_done, link_ptr == PW - 1);
         link_ptr = (link_ptr + 1) % PW;
         link_line++;
         if (bus.send_done) begin
            done_line++;
            done_tot++;
            if (auto_cons) due_q.push_back(cyc + 3);
         end
      end
      if (line_done) begin
         ld_cnt++;
         chk("line_done_pos", link_line, LINE_WORDS);
      end
      bus.src_valid = src_on && ($urandom_range(99) < valid_pct);
      bus.src_data  = next_word;
      cons = 0;
      if (due_q.size() != 0 && due_q[0] <= cyc) begin
         cons = 1;
         void'(due_q.pop_front());
      end
      if (arm_co && bus.src_valid && bus.src_ready && src_ptr == 0) begin
         cons   = 1;
         arm_co = 0;
      end
      bus.pkg_consumed = cons;
      if (cons) consumed++;
`ifdef MASTER_SEND_TX_STATS_EN
      if (((busy && !bus.src_ready && !line_done) || (bus.src_ready && !bus.src_valid))
          && stall_m < 65535) stall_m++;
`endif
      if (bus.src_valid && bus.src_ready) begin
         exp_q.push_back(next_word);
         next_word = {$urandom(), $urandom()};
         if (src_ptr == 0) begin
            started++;
            chk("in_flight_le_credit_max", (started - consumed) <= CMAX, 1);
         end
         src_ptr = (src_ptr + 1) % PW;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge s_clk);
      #1;
   endtask

   task automatic clear_model();
      exp_q.delete();
      due_q.delete();
      src_ptr = 0; link_ptr = 0; started = 0; consumed = 0; done_tot = 0;
      arm_co = 0;
   endtask

   task automatic start_line();
      @(negedge s_clk);
      #1;
      i_start   = 1'b1;
      link_line = 0; done_line = 0; ld_cnt = 0;
`ifdef MASTER_SEND_TX_STATS_EN
      stall_m = 0;
`endif
      cycles(1);
      i_start = 1'b0;
   endtask

   task automatic wait_line(input int lim);
      for (int i = 0; i < lim && ld_cnt == 0; i++) cycles(1);
      chk("line_done_seen", ld_cnt != 0, 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk(tag, {busy, line_done, credit_err, bus.send_valid, bus.send_done, bus.src_ready}, 6'b0);
      chk({tag, "_data"}, bus.send_data, '0);
   endtask

   task automatic check_line(input string tag);
      chk({tag, "_words"}, link_line, LINE_WORDS);
      chk({tag, "_dones"}, done_line, PL);
      chk({tag, "_line_done_cnt"}, ld_cnt, 1);
   endtask

`ifdef MASTER_SEND_TX_STATS_EN
   task automatic check_stats(input string tag);
      @(posedge s_clk);
      #1;
      chk(tag, stall_cycles, stall_m[15:0]);
   endtask
`endif

   int owed;

   initial begin
      bus.src_valid = 0; bus.src_data = '0; bus.pkg_consumed = 0;
      next_word = {$urandom(), $urandom()};
      cycles(3);
      check_idle_outputs("reset_state");
      s_rst = 0;
      cycles(2);

      // reset in the middle of the first packet
      src_on = 1; valid_pct = 100; auto_cons = 0;
      start_line();
      cycles(10);
      chk("mid_packet_sending", link_line > 0, 1);
      src_on = 0;
      @(negedge s_clk);
      #2;
      s_rst = 1;
      #1;
      clear_model();
      check_idle_outputs("reset_mid_packet");
      cycles(2);
      s_rst = 0;
      cycles(2);

      // credit stall: no returns -> CREDIT_MAX packets, then wait
      src_on = 1;
      start_line();
      cycles(250);
      chk("stall_words", link_line, CMAX * PW);
      chk("stall_dones", done_line, CMAX);
      chk("stall_ready_low", bus.src_ready, 0);
      chk("stall_busy", busy, 1);
`ifdef MASTER_SEND_TX_STATS_EN
      check_stats("stall_cycles_credit_wait");
`endif
      due_q.push_back(cyc + 1);
      cycles(60);
      chk("one_credit_one_packet", link_line, (CMAX + 1) * PW);
      chk("ready_low_again", bus.src_ready, 0);

      // return coinciding with the first-word transfer must leave the credit
      due_q.push_back(cyc + 1);
      arm_co = 1;
      cycles(80);
      chk("coincident_return_fired", arm_co, 0);
      chk("coincident_two_packets", link_line, (CMAX + 3) * PW);

      // release outstanding credits and finish the line
      auto_cons = 1;
      owed = done_tot - consumed;
      for (int i = 0; i < owed; i++) due_q.push_back(cyc + 2 + 2 * i);
      wait_line(3000);
      check_line("stalled_line");
      chk("no_credit_err", credit_err, 0);
      cycles(40);
      chk("idle_after_line", busy, 0);

      // surplus return at full credit -> sticky error, credit stays at max
      due_q.push_back(cyc + 1);
      cycles(4);
      chk("credit_err_set", credit_err, 1);
      cycles(4);
      chk("credit_err_sticky", credit_err, 1);
      auto_cons = 0;
      start_line();
      cycles(250);
      chk("credit_saturated_words", link_line, CMAX * PW);
      src_on = 0;
      @(negedge s_clk);
      #2;
      s_rst = 1;
      #1;
      clear_model();
      check_idle_outputs("reset_clears_err");
      cycles(2);
      s_rst = 0;
      cycles(2);

      // full line, source always valid, stray start while sending
      src_on = 1; valid_pct = 100; auto_cons = 1;
      start_line();
      cycles(50);
      i_start = 1'b1;
      cycles(1);
      i_start = 1'b0;
      wait_line(3000);
      check_line("full_line");
      cycles(60);
      chk("stray_start_ignored_busy", busy, 0);
      chk("stray_start_one_line", ld_cnt, 1);

      // bubbles on the source side
      valid_pct = 50;
      start_line();
      wait_line(6000);
      check_line("bubble_line");
`ifdef MASTER_SEND_TX_STATS_EN
      check_stats("stall_cycles_bubbles");
`endif
      cycles(60);
      chk("bubble_idle", busy, 0);
      chk("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
